// File: rtl/muldiv_pkg.sv
// Shared types and op decoding helpers for the iterative multiply/divide unit.
// Operand width, op encoding and FSM states live here so the top and its helper agree.
package muldiv_pkg;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 7;

  typedef logic [DATA_W-1:0] u64;
  typedef logic [2:0]        u3;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  function automatic logic isDivOp(input muldiv_op_t o);
    return o[2];
  endfunction

  function automatic logic isRemOp(input muldiv_op_t o);
    return o[2] & o[1];
  endfunction

  function automatic logic signedA(input muldiv_op_t o);
    return o inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic signedB(input muldiv_op_t o);
    return o inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: yields the magnitude of a signed operand
// at accept, and re-applies the result sign at completion.
module muldiv_sign_fix #(
  parameter int DATA_W = 64
) (
  input  logic [DATA_W-1:0] val,
  input  logic              neg,
  output logic [DATA_W-1:0] res
);

  assign res = neg ? ((~val) + DATA_W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 64-bit multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on magnitudes, 64 iterations, with sign fix-up and special-case bypass.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  u3    op,
  input  u64   ia,
  input  u64   ib,
  input  logic flush,
  output logic resp_valid,
  input  logic resp_ready,
  output u64   result
);

  localparam u64 MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  muldiv_state_t           state;
  muldiv_op_t              opReg;
  logic [2*DATA_W-1:0]     acc;
  u64                      opnd;
  logic [CNT_W-1:0]        cnt;
  logic                    negQ;
  logic                    negR;

  muldiv_op_t opIn;
  logic       signA, signB;
  u64         magA, magB;
  logic       divZero, divOvf;
  u64         specialRes;

  assign opIn  = muldiv_op_t'(op);
  assign signA = signedA(opIn) & ia[DATA_W-1];
  assign signB = signedB(opIn) & ib[DATA_W-1];

  muldiv_sign_fix #(.DATA_W(DATA_W)) uMagA (.val(ia), .neg(signA), .res(magA));
  muldiv_sign_fix #(.DATA_W(DATA_W)) uMagB (.val(ib), .neg(signB), .res(magB));

  assign divZero = isDivOp(opIn) && (ib == '0);
  assign divOvf  = (opIn == OP_DIV || opIn == OP_REM) && (ia == MIN_NEG) && (ib == '1);

  always_comb begin
    specialRes = '0;
    if (divZero) specialRes = isRemOp(opIn) ? ia : '1;
    else         specialRes = isRemOp(opIn) ? '0 : ia;
  end

  // Multiply keeps {partial product, multiplier}; divide keeps {remainder, quotient}.
  logic [DATA_W:0]     mulSum;
  logic [DATA_W:0]     divTrial;
  logic [2*DATA_W-1:0] accNext;

  assign mulSum   = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
  assign divTrial = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opnd};

  always_comb begin
    accNext = acc;
    if (isDivOp(opReg)) begin
      if (!divTrial[DATA_W]) accNext = {divTrial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      else                   accNext = {acc[2*DATA_W-2:0], 1'b0};
    end else begin
      if (acc[0]) accNext = {mulSum, acc[DATA_W-1:1]};
      else        accNext = {1'b0, acc[2*DATA_W-1:1]};
    end
  end

  logic [2*DATA_W-1:0] fixIn;
  logic [2*DATA_W-1:0] fixOut;
  logic                fixNeg;
  u64                  finalRes;

  always_comb begin
    fixIn = accNext;
    if (isDivOp(opReg)) begin
      if (isRemOp(opReg)) fixIn = {{DATA_W{1'b0}}, accNext[2*DATA_W-1:DATA_W]};
      else                fixIn = {{DATA_W{1'b0}}, accNext[DATA_W-1:0]};
    end
  end

  assign fixNeg = isRemOp(opReg) ? negR : negQ;

  muldiv_sign_fix #(.DATA_W(2*DATA_W)) uFix (.val(fixIn), .neg(fixNeg), .res(fixOut));

  assign finalRes = (opReg == OP_MUL || isDivOp(opReg)) ? fixOut[DATA_W-1:0]
                                                        : fixOut[2*DATA_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      opReg  <= OP_MUL;
      acc    <= '0;
      opnd   <= '0;
      cnt    <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            opReg <= opIn;
            negQ  <= signA ^ signB;
            negR  <= signA;
            cnt   <= '0;
            if (divZero || divOvf) begin
              result <= specialRes;
              state  <= ST_DONE;
            end else begin
              acc   <= {{DATA_W{1'b0}}, isDivOp(opIn) ? magA : magB};
              opnd  <= isDivOp(opIn) ? magB : magA;
              state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc <= accNext;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_W-1)) begin
            result <= finalRes;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state == ST_IDLE);
  assign resp_valid = (state == ST_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  op = 3'd0;
  logic [63:0] ia = '0;
  logic [63:0] ib = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [63:0] result;

  int checks = 0;
  int failures = 0;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .ia(ia), .ib(ib), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] refModel(input logic [2:0] o, input logic [63:0] a,
                                           input logic [63:0] b);
    logic signed [127:0] sa, sb, sp;
    logic [127:0] ua, ub, up;
    logic signed [63:0] a64, b64;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    a64 = a;
    b64 = b;
    case (o)
      3'd0: begin up = ua * ub; return up[63:0]; end
      3'd1: begin sp = sa * sb; return sp[127:64]; end
      3'd2: begin sp = sa * $signed(ub); return sp[127:64]; end
      3'd3: begin up = ua * ub; return up[127:64]; end
      3'd4: begin
        if (b == 64'd0) return ONES;
        if (a == MINV && b == ONES) return a;
        return a64 / b64;
      end
      3'd5: return (b == 64'd0) ? ONES : a / b;
      3'd6: begin
        if (b == 64'd0) return a;
        if (a == MINV && b == ONES) return 64'd0;
        return a64 % b64;
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    if (o[2] && b == 64'd0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == MINV && b == ONES) return 1;
    return 65;
  endfunction

  // Issues one op, measures edges from accept to resp_valid, optionally stalls in DONE.
  task automatic runOp(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input int hold, input string tag);
    logic [63:0] exp;
    int lat;
    int expLat;
    exp = refModel(o, a, b);
    expLat = refLatency(o, a, b);
    @(negedge clk);
    check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; op = o; ia = a; ib = b;
    @(negedge clk);
    req_valid = 1'b0; ia = {$urandom, $urandom}; ib = {$urandom, $urandom}; op = 3'($urandom);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(expLat));
    check({tag, "_res"}, result, exp);
    if (hold > 0) begin
      req_valid = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_holdv"}, {63'd0, resp_valid}, 64'd1);
        check({tag, "_holdr"}, result, exp);
        check({tag, "_holdrdy"}, {63'd0, req_ready}, 64'd0);
      end
      req_valid = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_handoff"}, {62'd0, resp_valid, req_ready}, 64'b01);
  endtask

  task automatic watchNoResp(input int cycles, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check(tag, {63'd0, seen}, 64'd0);
  endtask

  initial begin
    logic [2:0] ro;
    logic [63:0] ra, rb;
    int sel;

    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {63'd0, req_ready}, 64'd1);
    check("reset_valid", {63'd0, resp_valid}, 64'd0);
    check("reset_result", result, 64'd0);

    runOp(3'd0, 64'd7, ONES - 64'd2, 0, "mul_7xm3");
    runOp(3'd3, ONES, ONES, 0, "mulhu_ones");
    runOp(3'd1, ONES, ONES, 0, "mulh_ones");
    runOp(3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, "div_m7_2");
    runOp(3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 0, "rem_m7_2");
    runOp(3'd5, 64'd100, 64'd7, 0, "divu_100_7");
    runOp(3'd7, 64'd100, 64'd7, 0, "remu_100_7");
    runOp(3'd5, 64'd5, 64'd0, 0, "divu_zero");
    runOp(3'd6, MINV, ONES, 0, "rem_ovf");
    runOp(3'd4, MINV, ONES, 0, "div_ovf");
    runOp(3'd2, ONES, 64'd2, 10, "stall_mulhsu");

    // flush beats a simultaneous request in IDLE
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1; op = 3'd5; ia = 64'd5; ib = 64'd0;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("flush_vs_accept", {62'd0, resp_valid, req_ready}, 64'b01);
    watchNoResp(3, "flush_vs_accept_nores");

    // flush mid-BUSY around iteration 30
    @(negedge clk);
    req_valid = 1'b1; op = 3'd0; ia = 64'd12345; ib = 64'd678;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (29) @(negedge clk);
    check("flush_busy_pre", {62'd0, resp_valid, req_ready}, 64'b00);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_idle", {62'd0, resp_valid, req_ready}, 64'b01);
    watchNoResp(80, "flush_busy_nores");
    runOp(3'd2, ONES, 64'd2, 0, "post_flush_mulhsu");

    // asynchronous reset mid-BUSY
    @(negedge clk);
    req_valid = 1'b1; op = 3'd5; ia = 64'd1000; ib = 64'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy_outs", {61'd0, resp_valid, req_ready, 1'b0}, 64'b010);
    check("rst_busy_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watchNoResp(80, "rst_busy_nores");
    runOp(3'd2, ONES, 64'd2, 0, "post_rst_mulhsu");

    for (int n = 0; n < 24; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 64'd0;
      else if (sel == 1) begin ra = MINV; rb = ONES; end
      else if (sel == 2) rb = 64'($urandom_range(1, 100));
      else if (sel == 3) ra = -ra;
      runOp(ro, ra, rb, 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
